// File: rtl/char_buf_arbiter.sv
// char_buf_arbiter: 256-entry character buffer, round-robin write arbiter for two requesters, clear sequencer.
// Optional macro CHAR_BUF_VBLANK_WR_EN restricts grants and clear writes to vertical blank.
module char_buf_arbiter #(
    parameter int                ADDR_W     = 8,
    parameter int                CODE_W     = 7,
    parameter logic [CODE_W-1:0] CLEAR_CODE = 7'h20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] char_xy,
    output logic [CODE_W-1:0] char_code,
    input  logic              a_req,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [CODE_W-1:0] a_data,
    output logic              a_gnt,
    input  logic              b_req,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [CODE_W-1:0] b_data,
    output logic              b_gnt,
    input  logic              clr_req,
    input  logic              vblnk,
    output logic              busy
);
    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              last_b_q, last_b_d;
    logic [CODE_W-1:0] code_q;
    logic [CODE_W-1:0] mem [2**ADDR_W];
    logic              wr_ok, idle;

`ifdef CHAR_BUF_VBLANK_WR_EN
    assign wr_ok = vblnk;
`else
    logic unused_vblnk;
    assign unused_vblnk = vblnk;
    assign wr_ok = 1'b1;
`endif

    assign idle      = state_q == IDLE;
    // last_b_q set means B was served last, so A wins the next contention
    assign a_gnt     = idle && wr_ok && a_req && (!b_req || last_b_q);
    assign b_gnt     = idle && wr_ok && b_req && (!a_req || !last_b_q);
    assign busy      = state_q == CLEAR;
    assign char_code = code_q;

    always_comb begin
        last_b_d = a_gnt ? 1'b0 : b_gnt ? 1'b1 : last_b_q;
        state_d  = idle ? (clr_req ? CLEAR : IDLE) : (wr_ok && &cnt_q) ? IDLE : CLEAR;
        cnt_d    = idle ? '0 : wr_ok ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!idle && wr_ok)
            mem[cnt_q] <= CLEAR_CODE;
        else if (a_gnt)
            mem[a_addr] <= a_data;
        else if (b_gnt)
            mem[b_addr] <= b_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            last_b_q <= 1'b1;
            code_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_b_q <= last_b_d;
            code_q   <= mem[char_xy];
        end
    end
endmodule
